// File: rtl/halt_pkg.sv
// Shared types for the halt controller: FSM states, halt status codes and field widths.
package halt_pkg;

  localparam int unsigned PC_WIDTH   = 32;
  localparam int unsigned OP_WIDTH   = 32;
  localparam int unsigned EXIT_WIDTH = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_STEP,
    ST_PAUSED,
    ST_HALTED
  } state_t;

  typedef enum logic [1:0] {
    STAT_NONE    = 2'b00,
    STAT_OK      = 2'b01,
    STAT_ERROR   = 2'b10,
    STAT_TIMEOUT = 2'b11
  } status_t;

  // Error wins when the decoder flags ok and error together.
  function automatic status_t halt_code(input logic error);
    return error ? STAT_ERROR : STAT_OK;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with enable and synchronous clear; never wraps past all-ones.
module sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/halt_ctrl.sv
// Run/step/halt controller for a simple core: gates the core clock-enable, captures
// halt cause/pc/exit code and counts executed cycles with an optional watchdog.
module halt_ctrl
  import halt_pkg::*;
#(
  parameter int unsigned CYCLE_WIDTH    = 32,
  parameter int unsigned WATCHDOG_LIMIT = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ok_in,
  input  logic                   error_in,
  input  logic [OP_WIDTH-1:0]    op_code,
  input  logic [PC_WIDTH-1:0]    pc_in,
  input  logic                   start,
  input  logic                   step,
  input  logic                   resume,
  input  logic                   clear,
  output logic                   run_en,
  output logic                   halted,
  output logic [1:0]             halt_status,
  output logic [PC_WIDTH-1:0]    halt_pc,
  output logic [EXIT_WIDTH-1:0]  exit_code,
  output logic [CYCLE_WIDTH-1:0] cycle_count,
  output logic                   step_done
);

  localparam logic [CYCLE_WIDTH-1:0] WD_MATCH = CYCLE_WIDTH'(WATCHDOG_LIMIT - 1);

  state_t                  state_q, state_d;
  status_t                 status_q, status_d;
  logic [PC_WIDTH-1:0]     pc_q, pc_d;
  logic [EXIT_WIDTH-1:0]   exit_q, exit_d;
  logic                    step_done_q, step_done_d;
  logic                    halt_seen;
  logic                    timeout;
  logic                    unused_op_bits;

  assign unused_op_bits = ^{op_code[31:16], op_code[7:0]};

  // Clock-enable comes straight from state so reset drops it asynchronously.
  assign run_en = (state_q == ST_RUN) || (state_q == ST_STEP);
  assign halted = (state_q == ST_HALTED);

  assign halt_seen = run_en && (ok_in || error_in);
  assign timeout   = (WATCHDOG_LIMIT != 0) && (state_q == ST_RUN) && (cycle_count == WD_MATCH);

  assign halt_status = status_q;
  assign halt_pc     = pc_q;
  assign exit_code   = exit_q;
  assign step_done   = step_done_q;

  sat_counter #(
    .WIDTH(CYCLE_WIDTH)
  ) u_cycle_cnt (
    .clk  (clk),
    .rst  (rst),
    .en   (run_en),
    .clr  (clear),
    .count(cycle_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      status_q    <= STAT_NONE;
      pc_q        <= '0;
      exit_q      <= '0;
      step_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      status_q    <= status_d;
      pc_q        <= pc_d;
      exit_q      <= exit_d;
      step_done_q <= step_done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    status_d    = status_q;
    pc_d        = pc_q;
    exit_d      = exit_q;
    step_done_d = 1'b0;

    if (clear) begin
      state_d  = ST_IDLE;
      status_d = STAT_NONE;
      pc_d     = '0;
      exit_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (step)       state_d = ST_STEP;
          else if (start) state_d = ST_RUN;
        end
        ST_RUN: begin
          // A real halt in the watchdog cycle takes precedence over the timeout.
          if (halt_seen || timeout) begin
            state_d  = ST_HALTED;
            status_d = halt_seen ? halt_code(error_in) : STAT_TIMEOUT;
            pc_d     = pc_in;
            exit_d   = op_code[15:8];
          end
        end
        ST_STEP: begin
          if (halt_seen) begin
            state_d  = ST_HALTED;
            status_d = halt_code(error_in);
            pc_d     = pc_in;
            exit_d   = op_code[15:8];
          end else begin
            state_d     = ST_PAUSED;
            step_done_d = 1'b1;
          end
        end
        ST_PAUSED: begin
          if (step)                 state_d = ST_STEP;
          else if (start || resume) state_d = ST_RUN;
        end
        ST_HALTED: begin
          // Only clean halts may be resumed; error and timeout halts stick until clear.
          if (resume && (status_q == STAT_OK)) begin
            state_d  = ST_RUN;
            status_d = STAT_NONE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_halt_ctrl.sv
// Directed bench for halt_ctrl: default, watchdog (limit 8) and 4-bit counter instances share stimulus.
module tb_halt_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ok_in, error_in, start, step, resume, clear;
  logic [31:0] op_code, pc_in;

  logic        run_en_d, halted_d, step_done_d;
  logic [1:0]  status_d;
  logic [31:0] pc_d, count_d;
  logic [7:0]  exit_d;

  logic        run_en_w, halted_w, step_done_w;
  logic [1:0]  status_w;
  logic [31:0] pc_w, count_w;
  logic [7:0]  exit_w;

  logic        run_en_n, halted_n, step_done_n;
  logic [1:0]  status_n;
  logic [31:0] pc_n;
  logic [3:0]  count_n;
  logic [7:0]  exit_n;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  halt_ctrl dut (
    .clk(clk), .rst(rst), .ok_in(ok_in), .error_in(error_in), .op_code(op_code), .pc_in(pc_in),
    .start(start), .step(step), .resume(resume), .clear(clear),
    .run_en(run_en_d), .halted(halted_d), .halt_status(status_d), .halt_pc(pc_d),
    .exit_code(exit_d), .cycle_count(count_d), .step_done(step_done_d)
  );

  halt_ctrl #(.WATCHDOG_LIMIT(8)) dut_wd (
    .clk(clk), .rst(rst), .ok_in(ok_in), .error_in(error_in), .op_code(op_code), .pc_in(pc_in),
    .start(start), .step(step), .resume(resume), .clear(clear),
    .run_en(run_en_w), .halted(halted_w), .halt_status(status_w), .halt_pc(pc_w),
    .exit_code(exit_w), .cycle_count(count_w), .step_done(step_done_w)
  );

  halt_ctrl #(.CYCLE_WIDTH(4)) dut_narrow (
    .clk(clk), .rst(rst), .ok_in(ok_in), .error_in(error_in), .op_code(op_code), .pc_in(pc_in),
    .start(start), .step(step), .resume(resume), .clear(clear),
    .run_en(run_en_n), .halted(halted_n), .halt_status(status_n), .halt_pc(pc_n),
    .exit_code(exit_n), .cycle_count(count_n), .step_done(step_done_n)
  );

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    ok_in = 1'b0; error_in = 1'b0; start = 1'b0; step = 1'b0; resume = 1'b0; clear = 1'b0;
    op_code = 32'h0; pc_in = 32'h0;

    // Reset values
    #12;
    check("rst_run_en", 64'(run_en_d), 64'd0);
    check("rst_halted", 64'(halted_d), 64'd0);
    check("rst_status", 64'(status_d), 64'd0);
    check("rst_pc", 64'(pc_d), 64'd0);
    check("rst_exit", 64'(exit_d), 64'd0);
    check("rst_count", 64'(count_d), 64'd0);
    check("rst_step_done", 64'(step_done_d), 64'd0);
    rst = 1'b1;
    tick();

    // Clean halt on the fifth run cycle
    start = 1'b1; tick(); start = 1'b0;
    check("run_en_after_start", 64'(run_en_d), 64'd1);
    repeat (4) tick();
    ok_in = 1'b1; pc_in = 32'h40; op_code = 32'h0000_2A00;
    check("not_halted_at_detect", 64'(halted_d), 64'd0);
    tick(); ok_in = 1'b0;
    check("ok_halted", 64'(halted_d), 64'd1);
    check("ok_run_en", 64'(run_en_d), 64'd0);
    check("ok_status", 64'(status_d), 64'd1);
    check("ok_pc", 64'(pc_d), 64'h40);
    check("ok_exit", 64'(exit_d), 64'h2A);
    check("ok_count", 64'(count_d), 64'd5);

    // Resume after clean halt
    resume = 1'b1; tick(); resume = 1'b0;
    check("resume_halted", 64'(halted_d), 64'd0);
    check("resume_status", 64'(status_d), 64'd0);
    check("resume_run_en", 64'(run_en_d), 64'd1);
    check("resume_count", 64'(count_d), 64'd5);

    // ok and error together: error wins and is sticky
    ok_in = 1'b1; error_in = 1'b1; tick(); ok_in = 1'b0; error_in = 1'b0;
    check("err_status", 64'(status_d), 64'd2);
    check("err_count", 64'(count_d), 64'd6);
    resume = 1'b1; tick(); resume = 1'b0;
    check("err_resume_halted", 64'(halted_d), 64'd1);
    check("err_resume_status", 64'(status_d), 64'd2);
    clear = 1'b1; tick(); clear = 1'b0;
    check("clr_halted", 64'(halted_d), 64'd0);
    check("clr_run_en", 64'(run_en_d), 64'd0);
    check("clr_status", 64'(status_d), 64'd0);
    check("clr_pc", 64'(pc_d), 64'd0);
    check("clr_exit", 64'(exit_d), 64'd0);
    check("clr_count", 64'(count_d), 64'd0);

    // Resume from idle is ignored
    resume = 1'b1; tick(); resume = 1'b0;
    check("idle_resume_run_en", 64'(run_en_d), 64'd0);

    // Three single steps
    for (int i = 1; i <= 3; i++) begin
      step = 1'b1; tick(); step = 1'b0;
      check("step_run_en", 64'(run_en_d), 64'd1);
      check("step_done_early", 64'(step_done_d), 64'd0);
      tick();
      check("step_run_en_off", 64'(run_en_d), 64'd0);
      check("step_done_pulse", 64'(step_done_d), 64'd1);
      check("step_count", 64'(count_d), 64'(i));
      tick();
      check("step_done_clear", 64'(step_done_d), 64'd0);
    end

    // step beats start from PAUSED
    step = 1'b1; start = 1'b1; tick(); step = 1'b0; start = 1'b0;
    check("prio_step_run_en", 64'(run_en_d), 64'd1);
    tick();
    check("prio_step_paused", 64'(run_en_d), 64'd0);
    check("prio_step_done", 64'(step_done_d), 64'd1);
    check("prio_step_count", 64'(count_d), 64'd4);

    // clear beats start
    clear = 1'b1; start = 1'b1; tick(); clear = 1'b0; start = 1'b0;
    check("prio_clr_run_en", 64'(run_en_d), 64'd0);
    check("prio_clr_count", 64'(count_d), 64'd0);

    // Watchdog timeout after 8 run cycles, narrow counter saturates
    start = 1'b1; tick(); start = 1'b0;
    repeat (7) tick();
    check("wd_pre_halted", 64'(halted_w), 64'd0);
    check("wd_pre_count", 64'(count_w), 64'd7);
    tick();
    check("wd_halted", 64'(halted_w), 64'd1);
    check("wd_status", 64'(status_w), 64'd3);
    check("wd_count", 64'(count_w), 64'd8);
    check("nowd_run_en", 64'(run_en_d), 64'd1);
    repeat (12) tick();
    check("wide_count", 64'(count_d), 64'd20);
    check("narrow_count_sat", 64'(count_n), 64'd15);
    check("narrow_run_en", 64'(run_en_n), 64'd1);
    check("wd_count_held", 64'(count_w), 64'd8);

    // Real halt in the watchdog cycle records the real halt
    clear = 1'b1; tick(); clear = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    repeat (7) tick();
    ok_in = 1'b1; pc_in = 32'h80; tick(); ok_in = 1'b0;
    check("wd_tie_status", 64'(status_w), 64'd1);
    check("wd_tie_pc", 64'(pc_w), 64'h80);
    check("wd_tie_count", 64'(count_w), 64'd8);

    // Reset mid-run with a pending error halt
    clear = 1'b1; tick(); clear = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    repeat (2) tick();
    error_in = 1'b1;
    check("pre_rst_run_en", 64'(run_en_d), 64'd1);
    #2 rst = 1'b0;
    #1;
    check("async_rst_run_en", 64'(run_en_d), 64'd0);
    tick();
    check("in_rst_halted", 64'(halted_d), 64'd0);
    error_in = 1'b0;
    rst = 1'b1;
    tick();
    check("post_rst_run_en", 64'(run_en_d), 64'd0);
    check("post_rst_halted", 64'(halted_d), 64'd0);
    check("post_rst_status", 64'(status_d), 64'd0);
    check("post_rst_pc", 64'(pc_d), 64'd0);
    check("post_rst_exit", 64'(exit_d), 64'd0);
    check("post_rst_count", 64'(count_d), 64'd0);
    check("post_rst_step_done", 64'(step_done_d), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/halt_ctrl.md
HALT_CTRL -- requirements
Module: halt_ctrl

Interface
REQ-001 Parameter CYCLE_WIDTH, default 32, width of the executed-cycle counter.
REQ-002 Parameter WATCHDOG_LIMIT, default 0, cycle count that forces a timeout halt; 0 disables the watchdog.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 ok_in  in  1  clean-halt indication from the halt decoder, combinational, valid only while run_en=1.
REQ-006 error_in  in  1  error-halt indication from the halt decoder, same validity as ok_in.
REQ-007 op_code  in  32  instruction currently executing.
REQ-008 pc_in  in  32  address of the instruction currently executing.
REQ-009 start  in  1  begin free-running execution.
REQ-010 step  in  1  execute exactly one instruction.
REQ-011 resume  in  1  continue after a pause or a clean halt.
REQ-012 clear  in  1  return to idle and wipe captured status.
REQ-013 run_en  out  1  core clock-enable; the core advances one instruction per cycle with run_en=1.
REQ-014 halted  out  1  high while in HALTED.
REQ-015 halt_status  out  2  00 none, 01 ok, 10 error, 11 watchdog timeout.
REQ-016 halt_pc  out  32  pc_in captured at the halt.
REQ-017 exit_code  out  8  op_code[15:8] captured at the halt.
REQ-018 cycle_count  out  CYCLE_WIDTH  count of cycles with run_en=1.
REQ-019 step_done  out  1  one-cycle pulse when a single step completes without halting.

Function
REQ-020 The FSM SHALL have the states IDLE, RUN, STEP, PAUSED and HALTED.
REQ-021 run_en SHALL be 1 in RUN and STEP only; it is decoded from state, with no extra register stage.
REQ-022 ok_in and error_in SHALL be sampled only when run_en=1; they are ignored in every other state.
REQ-023 A sampled halt SHALL move the FSM to HALTED on the next edge and capture halt_pc, exit_code and halt_status in that same edge, so halted=1 one cycle after detection.
REQ-024 When ok_in=1 and error_in=1 together, status SHALL be 10 (error wins).
REQ-025 Command priority SHALL be clear > step > start/resume; only the highest-priority command present acts.
REQ-026 IDLE: step goes to STEP; start goes to RUN; resume is ignored.
REQ-027 RUN: a halt goes to HALTED; a watchdog timeout goes to HALTED with status 11; start, step and resume are ignored; clear goes to IDLE.
REQ-028 STEP SHALL last exactly one cycle: a halt goes to HALTED; otherwise the FSM goes to PAUSED and step_done=1 in the first PAUSED cycle.
REQ-029 PAUSED: start or resume goes to RUN; step goes to STEP; clear goes to IDLE.
REQ-030 HALTED: resume with status 01 clears status to 00 and goes to RUN; resume with status 10 or 11 is ignored (error halts are sticky); clear goes to IDLE.
REQ-031 Entering IDLE via clear SHALL zero halt_status, halt_pc, exit_code and cycle_count.
REQ-032 cycle_count SHALL increment each cycle with run_en=1 and saturate at all-ones with no wrap.
REQ-033 Timeout SHALL fire when WATCHDOG_LIMIT != 0, state is RUN and cycle_count == WATCHDOG_LIMIT-1 at the edge.
REQ-034 A real halt and a timeout in the same cycle SHALL record the real halt.

Reset
REQ-035 While rst=0: state IDLE, run_en 0, halted 0, halt_status 00, halt_pc 0, exit_code 0, cycle_count 0, step_done 0.
REQ-036 Reset asserted mid-RUN SHALL drop run_en in the same cycle (asynchronously) and discard any pending halt.

Structure
REQ-037 The shared package halt_pkg SHALL hold the state enum and the status codes (none, ok, error, timeout).
REQ-038 The counter SHALL be one sub-module, sat_counter (enable, sync clear, saturation), parameterised by width.

Verification
REQ-039 Reset, start, ok_in=1 at cycle 5 with pc_in=0x40 and op_code=0x00002A00 -> halted=1 next cycle; status 01, halt_pc 0x40, exit_code 0x2A, cycle_count 5.
REQ-040 ok_in=1 and error_in=1 together in RUN -> status 10; a subsequent resume is ignored; clear -> IDLE with all captured fields zero.
REQ-041 step three times from IDLE, no halt -> three step_done pulses, each run_en pulse exactly one cycle wide, cycle_count 3.
REQ-042 WATCHDOG_LIMIT=8, start, no halt -> halted after 8 run cycles, status 11, cycle_count 8.
REQ-043 CYCLE_WIDTH=4, run 20 cycles -> cycle_count holds at 15.
REQ-044 rst low mid-RUN with error_in=1 -> run_en 0 immediately; after release all outputs at reset values and status 00.
